// File: rtl/tdm_demux8_if.sv
// Slot-multiplexed link on one side, eight parallel lanes plus framing status on the other.
// The demux takes the slave side; whatever drives the link and reads the lanes takes the master side.
interface tdm_demux8_if #(
  parameter int W = 2
);
  logic [W-1:0]   din;
  logic           din_valid;
  logic           sof;
  logic [8*W-1:0] dout;
  logic           dout_valid;
  logic           locked;
  logic           sync_lost;
  logic [2:0]     slot;
  logic [7:0]     frame_cnt;

  modport master (
    output din, din_valid, sof,
    input  dout, dout_valid, locked, sync_lost, slot, frame_cnt
  );

  modport slave (
    input  din, din_valid, sof,
    output dout, dout_valid, locked, sync_lost, slot, frame_cnt
  );
endinterface

// File: rtl/tdm_demux8.sv
// Purpose: 1-to-8 TDM demultiplexer; locks on sof, stages slots 0..6, publishes all eight lanes per frame.
// Latency: a frame appears on dout one cycle after its slot-7 beat, with dout_valid high for that cycle.
// Backpressure: none; idle cycles (din_valid=0) simply hold all state, and there is no timeout.
module tdm_demux8 #(
  parameter int W = 2
) (
  input  logic          clk,
  input  logic          reset,
  tdm_demux8_if.slave   bus
);

  typedef enum logic {HUNT, SYNC} state_t;

  state_t         state;
  logic [2:0]     slot_q;
  logic [W-1:0]   stage [0:6];
  logic [8*W-1:0] dout_q;
  logic           dout_valid_q;
  logic           sync_lost_q;
  logic [7:0]     frame_cnt_q;
  logic [8*W-1:0] frame_next;

  // Completed frame: staged lanes 0..6 plus the slot-7 word straight from the link.
  always_comb begin
    frame_next = '0;
    for (int k = 0; k < 7; k++) begin
      frame_next[k*W +: W] = stage[k];
    end
    frame_next[7*W +: W] = bus.din;
  end

  // Framing FSM: hunt for sof, steer slots into staging, publish on slot 7, resync on errors.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= HUNT;
      slot_q       <= 3'd0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_lost_q  <= 1'b0;
      frame_cnt_q  <= 8'd0;
      for (int k = 0; k < 7; k++) begin
        stage[k] <= '0;
      end
    end else begin
      // Strobes are single-cycle unless re-raised below.
      dout_valid_q <= 1'b0;
      sync_lost_q  <= 1'b0;
      if (bus.din_valid) begin
        case (state)
          HUNT: begin
            if (bus.sof) begin
              stage[0] <= bus.din;
              slot_q   <= 3'd1;
              state    <= SYNC;
            end
          end
          SYNC: begin
            if (bus.sof) begin
              // A marker anywhere but slot 0 abandons the partial frame but keeps lock,
              // since the marker itself tells us where the new frame begins.
              if (slot_q != 3'd0) begin
                sync_lost_q <= 1'b1;
              end
              stage[0] <= bus.din;
              slot_q   <= 3'd1;
            end else if (slot_q == 3'd0) begin
              // Expected a marker and did not get one: framing is unknown, drop lock.
              sync_lost_q <= 1'b1;
              slot_q      <= 3'd0;
              state       <= HUNT;
            end else if (slot_q == 3'd7) begin
              dout_q       <= frame_next;
              dout_valid_q <= 1'b1;
              frame_cnt_q  <= frame_cnt_q + 8'd1;
              slot_q       <= 3'd0;
            end else begin
              for (int k = 1; k < 7; k++) begin
                if (slot_q == 3'(k)) begin
                  stage[k] <= bus.din;
                end
              end
              slot_q <= slot_q + 3'd1;
            end
          end
          default: begin
            state  <= HUNT;
            slot_q <= 3'd0;
          end
        endcase
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.locked     = (state == SYNC);
  assign bus.sync_lost  = sync_lost_q;
  assign bus.slot       = slot_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed table of beats with hand-computed expectations, plus hand sequences for
// asynchronous mid-frame reset and the frame counter wrap.
module tb_tdm_demux8;

  typedef struct {
    logic        rst;
    logic        vld;
    logic        sof;
    logic [1:0]  din;
    logic [15:0] e_dout;
    logic        e_dv;
    logic        e_lk;
    logic        e_lost;
    logic [2:0]  e_slot;
    logic [7:0]  e_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   nvec = 0;
  int   nfail = 0;
  vec_t vecs[$];

  tdm_demux8_if #(.W(2)) bus ();

  tdm_demux8 #(.W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic rst, logic vld, logic sof, logic [1:0] din,
                              logic [15:0] e_dout, logic e_dv, logic e_lk,
                              logic e_lost, logic [2:0] e_slot, logic [7:0] e_cnt);
    vec_t v;
    v.rst = rst; v.vld = vld; v.sof = sof; v.din = din;
    v.e_dout = e_dout; v.e_dv = e_dv; v.e_lk = e_lk;
    v.e_lost = e_lost; v.e_slot = e_slot; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(string name, logic [15:0] e_dout, logic e_dv, logic e_lk,
                       logic e_lost, logic [2:0] e_slot, logic [7:0] e_cnt);
    nvec++;
    if (bus.dout !== e_dout || bus.dout_valid !== e_dv || bus.locked !== e_lk ||
        bus.sync_lost !== e_lost || bus.slot !== e_slot || bus.frame_cnt !== e_cnt) begin
      nfail++;
      $display("FAIL %s: got dout=%h dv=%b locked=%b lost=%b slot=%0d cnt=%0d, want dout=%h dv=%b locked=%b lost=%b slot=%0d cnt=%0d",
               name, bus.dout, bus.dout_valid, bus.locked, bus.sync_lost, bus.slot, bus.frame_cnt,
               e_dout, e_dv, e_lk, e_lost, e_slot, e_cnt);
    end
  endtask

  // Drive one cycle at the falling edge, let the rising edge sample it, settle 1 time unit.
  task automatic drive(logic rst, logic vld, logic sof, logic [1:0] din);
    @(negedge clk);
    reset         = rst;
    bus.din_valid = vld;
    bus.sof       = sof;
    bus.din       = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]  d;
    logic [15:0] e_fr;

    bus.din = 2'd0; bus.din_valid = 1'b0; bus.sof = 1'b0;

    // Test 1: HUNT discards beats without sof.
    vecs.push_back(mk(0,1,0,3, 16'h0000,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,3, 16'h0000,0,0,0,0,0));
    vecs.push_back(mk(0,0,1,3, 16'h0000,0,0,0,0,0));
    // Test 2: clean frame 0,1,2,3,0,1,2,3.
    for (int k = 0; k < 7; k++)
      vecs.push_back(mk(0,1,(k == 0),2'(k % 4), 16'h0000,0,1,0,3'(k + 1),0));
    vecs.push_back(mk(0,1,0,3, 16'hE4E4,1,1,0,0,1));
    vecs.push_back(mk(0,0,0,0, 16'hE4E4,0,1,0,0,1));
    vecs.push_back(mk(0,0,0,0, 16'hE4E4,0,1,0,0,1));
    // Test 3: reset, gapped frame (idles carry sof=1 to prove they are ignored), back-to-back all-ones frame.
    vecs.push_back(mk(1,0,0,0, 16'h0000,0,0,0,0,0));
    for (int k = 0; k < 7; k++) begin
      vecs.push_back(mk(0,1,(k == 0),2'(k % 4), 16'h0000,0,1,0,3'(k + 1),0));
      vecs.push_back(mk(0,0,1,3,               16'h0000,0,1,0,3'(k + 1),0));
    end
    vecs.push_back(mk(0,1,0,3, 16'hE4E4,1,1,0,0,1));
    vecs.push_back(mk(0,1,1,3, 16'hE4E4,0,1,0,1,1));
    for (int k = 1; k < 7; k++)
      vecs.push_back(mk(0,1,0,3, 16'hE4E4,0,1,0,3'(k + 1),1));
    vecs.push_back(mk(0,1,0,3, 16'hFFFF,1,1,0,0,2));
    // Test 4: early marker at slot 4, then 7 more beats of 1.
    vecs.push_back(mk(0,1,1,0, 16'hFFFF,0,1,0,1,2));
    for (int k = 1; k < 4; k++)
      vecs.push_back(mk(0,1,0,0, 16'hFFFF,0,1,0,3'(k + 1),2));
    vecs.push_back(mk(0,1,1,1, 16'hFFFF,0,1,1,1,2));
    for (int k = 1; k < 7; k++)
      vecs.push_back(mk(0,1,0,1, 16'hFFFF,0,1,0,3'(k + 1),2));
    vecs.push_back(mk(0,1,0,1, 16'h5555,1,1,0,0,3));
    // Test 5: missing marker drops lock; non-sof beats ignored; sof relocks.
    vecs.push_back(mk(0,1,0,2, 16'h5555,0,0,1,0,3));
    vecs.push_back(mk(0,1,0,3, 16'h5555,0,0,0,0,3));
    vecs.push_back(mk(0,0,1,3, 16'h5555,0,0,0,0,3));
    vecs.push_back(mk(0,1,1,1, 16'h5555,0,1,0,1,3));
    // Distinct lanes 1,0,2,3,3,1,0,2 to pin lane ordering.
    vecs.push_back(mk(0,1,0,0, 16'h5555,0,1,0,2,3));
    vecs.push_back(mk(0,1,0,2, 16'h5555,0,1,0,3,3));
    vecs.push_back(mk(0,1,0,3, 16'h5555,0,1,0,4,3));
    vecs.push_back(mk(0,1,0,3, 16'h5555,0,1,0,5,3));
    vecs.push_back(mk(0,1,0,1, 16'h5555,0,1,0,6,3));
    vecs.push_back(mk(0,1,0,0, 16'h5555,0,1,0,7,3));
    vecs.push_back(mk(0,1,0,2, 16'h87E1,1,1,0,0,4));

    // Async reset state, checked before any clock edge.
    #2 reset = 1'b1;
    #1 check("reset_state", 16'h0000,0,0,0,0,0);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].sof, vecs[i].din);
      check($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_dv, vecs[i].e_lk,
            vecs[i].e_lost, vecs[i].e_slot, vecs[i].e_cnt);
    end

    // Test 6a: assert reset at slot 5 between clock edges.
    drive(0,1,1,0);
    check("midframe_sof", 16'h87E1,0,1,0,1,4);
    for (int k = 1; k < 5; k++) drive(0,1,0,3);
    check("midframe_slot5", 16'h87E1,0,1,0,5,4);
    #2 reset = 1'b1;
    #1 check("midframe_async_reset", 16'h0000,0,0,0,0,0);
    drive(0,1,0,3);
    check("after_reset_hunt", 16'h0000,0,0,0,0,0);

    // Test 6b: 256 clean frames; counter wraps 255 -> 0.
    for (int f = 0; f < 256; f++) begin
      d = 2'(f % 4);
      drive(0,1,1,d);
      for (int k = 1; k < 8; k++) drive(0,1,0,d);
      e_fr = {8{d}};
      check($sformatf("wrap_frame%0d", f), e_fr,1,1,0,0,8'(f + 1));
    end
    drive(0,0,0,0);
    check("wrap_idle", 16'hFFFF,0,1,0,0,0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/tdm_demux8.md
# tdm_demux8

Registered 1-to-8 time-division demultiplexer: the receiving end of a slot-multiplexed link whose transmit side is an 8:1 mux stepping its select through slots 0..7. The block locks to a start-of-frame marker, steers each incoming slot word to its lane, and presents all eight lanes in parallel once per frame with a one-cycle valid strobe. It also detects framing loss and resynchronises. It sits downstream of the mux datapath, feeding per-channel logic.

## Interface
- W, default 2: data width of one slot word (W >= 1).
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- din  input  W  slot word from the multiplexed link.
- din_valid  input  1  din carries a slot word this cycle; otherwise the cycle is idle and ignored.
- sof  input  1  start-of-frame marker; meaningful only when din_valid=1; marks the beat as slot 0.
- dout  output  8*W  frame output; lane k occupies dout[k*W +: W].
- dout_valid  output  1  one-cycle pulse when dout is updated with a complete frame.
- locked  output  1  high while in SYNC state.
- sync_lost  output  1  one-cycle pulse on a framing error.
- slot  output  3  index of the next expected slot (0..7).
- frame_cnt  output  8  count of completed frames, wraps 255 -> 0.

## Operation
- States: HUNT and SYNC. Registered state, slot counter, seven staging registers (lanes 0..6, W bits each), and the dout register.
- HUNT: beats without sof are discarded. A beat with din_valid=1 and sof=1 stores din into staging lane 0, sets slot=1, and moves to SYNC.
- SYNC, beat with sof=0 and slot in 1..7: store din into lane[slot] and increment slot. On slot 7, load dout = {din, staging[6..0]}, pulse dout_valid, increment frame_cnt, and set slot=0. Lane 7 goes straight from din to dout and is not staged.
- SYNC, beat with sof=1 and slot=0: normal frame start. Store lane 0 and set slot=1.
- SYNC, beat with sof=1 and slot != 0 (early marker):
  - Pulse sync_lost and discard the partial frame; dout and frame_cnt are unchanged.
  - Treat this beat as slot 0: store lane 0, set slot=1, and stay in SYNC.
- SYNC, beat with sof=0 and slot=0 (missing marker): pulse sync_lost, discard the beat, set slot=0, and go to HUNT.
- Idle cycles (din_valid=0) change nothing. There is no timeout.
- dout holds its last complete frame until the next complete frame. Staging contents are never visible on dout.
- frame_cnt counts only completed frames.
- locked = (state == SYNC).

## Timing
- Async reset, effective immediately and for any state or mid-frame position. Outputs and state at reset:
  - state=HUNT, slot=0, all staging registers 0.
  - dout=0, dout_valid=0, sync_lost=0, locked=0, frame_cnt=0.
- All updates occur on the rising clk edge where din_valid=1 is sampled.
- dout, dout_valid and frame_cnt change on the edge that samples slot 7. dout_valid is high for exactly the following cycle.
- Latency: the frame appears on dout 1 cycle after its slot-7 beat.
- Back-to-back frames need no gap. A slot-7 beat followed immediately by a sof beat produces dout_valid=1 while the new slot 0 is being captured.
- sync_lost rises in the cycle after the offending beat and lasts 1 cycle.
- dout_valid and sync_lost are never high in the same cycle: an error beat never completes a frame.
- Reset asserted mid-frame discards the partial frame. After release, the block needs a new sof.
- slot and locked are registered and reflect state after the last edge.

## Test plan
All cases use W=2.

1. Reset then HUNT discard:
   - Stimulus: reset pulse, then beats din=3 with sof=0.
   - Required: dout=0, locked=0, slot=0, no dout_valid.
2. Single clean frame:
   - Stimulus: sof on the first beat; din sequence 0,1,2,3,0,1,2,3 on 8 consecutive valid cycles.
   - Required: one cycle after the 8th beat, dout=16'hE4E4, dout_valid=1 for 1 cycle, frame_cnt=1.
3. Gapped and back-to-back frames:
   - Stimulus: same frame with din_valid=0 idles inserted between beats, followed directly by a second frame of all 2'b11.
   - Required: first dout=16'hE4E4; second dout=16'hFFFF; two dout_valid pulses; frame_cnt=2.
4. Early marker:
   - Stimulus: sof at slot 4 mid-frame, then 7 more beats of din=1.
   - Required: sync_lost pulse; locked stays 1; previous dout and frame_cnt unchanged until the next completion; then dout=16'h5555.
5. Missing marker:
   - Stimulus: a complete frame, then a valid beat with sof=0.
   - Required: sync_lost pulse, locked=0, slot=0; later beats ignored until the next sof.
6. Reset mid-frame and counter wrap:
   - Stimulus: assert reset at slot 5; separately, run 256 clean frames.
   - Required: reset mid-frame gives all outputs 0 immediately. After 256 frames, frame_cnt wraps to 0.
